// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Writeback, read and reservation signals between the CPU pipeline and the register file.
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic                  wa_valid;
  logic                  wa_ready;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  busy_a;
  logic                  busy_b;
  logic                  rsv_valid;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic [DEPTH-1:0]      pending;

  modport master (
    output wa_valid, wa_addr, wa_data,
    output wb_valid, wb_addr, wb_data,
    output rd_addr_a, rd_addr_b, rsv_valid, rsv_addr,
    input  wa_ready, wb_ready, rd_data_a, rd_data_b, busy_a, busy_b, pending
  );

  modport slave (
    input  wa_valid, wa_addr, wa_data,
    input  wb_valid, wb_addr, wb_data,
    input  rd_addr_a, rd_addr_b, rsv_valid, rsv_addr,
    output wa_ready, wb_ready, rd_data_a, rd_data_b, busy_a, busy_b, pending
  );

endinterface

// File: rtl/r2w1_port_ram.sv
// Register storage: one write port, two registered read ports returning pre-write data.
module r2w1_port_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= data_in;
    data_a <= mem[addr_a];
    data_b <= mem[addr_b];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: bitmap of registers awaiting a load return, plus registered lookups.
module regfile_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        set_valid,
  input  logic [ADDR_WIDTH-1:0]       set_addr,
  input  logic                        clr_valid,
  input  logic [ADDR_WIDTH-1:0]       clr_addr,
  input  logic [ADDR_WIDTH-1:0]       look_addr_a,
  input  logic [ADDR_WIDTH-1:0]       look_addr_b,
  output logic [(1<<ADDR_WIDTH)-1:0]  pending,
  output logic                        busy_a,
  output logic                        busy_b
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] set_mask_c;
  logic [DEPTH-1:0] clr_mask_c;
  logic [DEPTH-1:0] pending_next_c;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    set_mask_c = '0;
    clr_mask_c = '0;
    if (set_valid) set_mask_c[set_addr] = 1'b1;
    if (clr_valid) clr_mask_c[clr_addr] = 1'b1;
    pending_next_c = (pending & ~clr_mask_c) | set_mask_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      busy_a  <= 1'b0;
      busy_b  <= 1'b0;
    end else begin
      pending <= pending_next_c;
      busy_a  <= pending_next_c[look_addr_a];
      busy_b  <= pending_next_c[look_addr_b];
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port between execute (A) and load return (B) writebacks,
// with round-robin arbitration, write-to-read bypass and a pending-load scoreboard.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_port_arbiter_if.slave  bus
);

  grant_e                last_grant;
  logic                  grant_a_c;
  logic                  grant_b_c;
  logic                  we_c;
  logic [ADDR_WIDTH-1:0] addr_w_c;
  logic [DATA_WIDTH-1:0] data_w_c;

  logic [DATA_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_b;

  logic                  primed;
  logic                  byp_valid;
  logic [ADDR_WIDTH-1:0] byp_addr;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [ADDR_WIDTH-1:0] rd_addr_a_q;
  logic [ADDR_WIDTH-1:0] rd_addr_b_q;
  logic [DATA_WIDTH-1:0] rd_a_c;
  logic [DATA_WIDTH-1:0] rd_b_c;

  // Ready is a function of valid and last_grant only; both are held low during reset.
  always_comb begin
    grant_a_c = !reset && bus.wa_valid && (!bus.wb_valid || last_grant == GRANT_B);
    grant_b_c = !reset && bus.wb_valid && !grant_a_c;
    we_c      = grant_a_c || grant_b_c;
    addr_w_c  = grant_a_c ? bus.wa_addr : bus.wb_addr;
    data_w_c  = grant_a_c ? bus.wa_data : bus.wb_data;
  end

  assign bus.wa_ready = grant_a_c;
  assign bus.wb_ready = grant_b_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_B;
    end else if (we_c) begin
      last_grant <= grant_a_c ? GRANT_A : GRANT_B;
    end
  end

  r2w1_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (we_c),
    .addr_w  (addr_w_c),
    .data_in (data_w_c),
    .addr_a  (bus.rd_addr_a),
    .addr_b  (bus.rd_addr_b),
    .data_a  (ram_a),
    .data_b  (ram_b)
  );

  // Commit and read addresses captured together so a same-edge write can override stale RAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed      <= 1'b0;
      byp_valid   <= 1'b0;
      byp_addr    <= '0;
      byp_data    <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else begin
      primed      <= 1'b1;
      byp_valid   <= we_c;
      byp_addr    <= addr_w_c;
      byp_data    <= data_w_c;
      rd_addr_a_q <= bus.rd_addr_a;
      rd_addr_b_q <= bus.rd_addr_b;
    end
  end

  always_comb begin
    rd_a_c = ram_a;
    rd_b_c = ram_b;
    if (byp_valid && byp_addr == rd_addr_a_q) rd_a_c = byp_data;
    if (byp_valid && byp_addr == rd_addr_b_q) rd_b_c = byp_data;
    if (!primed) begin
      rd_a_c = '0;
      rd_b_c = '0;
    end
  end

  assign bus.rd_data_a = rd_a_c;
  assign bus.rd_data_b = rd_b_c;

  // Only a load return (B) retires a reservation.
  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_valid   (bus.rsv_valid),
    .set_addr    (bus.rsv_addr),
    .clr_valid   (grant_b_c),
    .clr_addr    (bus.wb_addr),
    .look_addr_a (bus.rd_addr_a),
    .look_addr_b (bus.rd_addr_b),
    .pending     (bus.pending),
    .busy_a      (bus.busy_a),
    .busy_b      (bus.busy_b)
  );

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the register file's single write port between two writeback sources and sequences its two read ports. Requester A is execute writeback; requester B is load/IO return. The block contains the storage, a round-robin write arbiter with valid/ready handshake, write-to-read bypass, and a pending-register scoreboard that flags operands still awaiting a load return. It sits between the CPU issue/writeback stages and the register storage.

## Interface
- DATA_WIDTH, default 32: register width
- ADDR_WIDTH, default 5: register index width; depth 2**ADDR_WIDTH
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- wa_valid / wa_ready  in / out  1  requester A handshake
- wa_addr / wa_data  in  ADDR_WIDTH / DATA_WIDTH  requester A write
- wb_valid / wb_ready  in / out  1  requester B handshake
- wb_addr / wb_data  in  ADDR_WIDTH / DATA_WIDTH  requester B write
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  read addresses, sampled every cycle
- rd_data_a, rd_data_b  out  DATA_WIDTH  read data, 1-cycle latency
- busy_a, busy_b  out  1  sampled register was pending; rd_data is stale
- rsv_valid  in  1  reserve destination of an issued load
- rsv_addr  in  ADDR_WIDTH  register to reserve
- pending  out  2**ADDR_WIDTH  scoreboard bitmap

## Operation
- Arbitration:
  - wa_ready = wa_valid & (~wb_valid | last_grant==B); wb_ready = wb_valid & ~wa_ready.
  - Ready depends only on valid and state; there is no ready-to-valid combinational path.
  - last_grant updates only on a granted write. It resets to B, so A wins the first contest.
- Exactly one write commits per cycle, at the edge where valid & ready. Requesters hold addr/data stable while valid & ~ready.
- Commit drives the storage write port (we, addr_w, data_in) from the granted requester.
- Scoreboard:
  - rsv_valid sets pending[rsv_addr].
  - A commit from B clears pending[wb_addr]. A commit from A never clears.
  - Set and clear of the same index in one cycle: set wins.
  - Reserving an already-pending index leaves it set; upstream must not do this, and the bench asserts it.
- Bypass (write-first semantics):
  - The storage returns old data when a read and write hit the same address in the same cycle.
  - The block registers the commit (valid/addr/data) alongside the sampled read addresses.
  - If the registered commit address matches a registered read address, the output takes the registered commit data.
- busy_x is registered: the next-state pending bit of rd_addr_x at the sampling edge. A read that samples in the same cycle as a clearing commit sees busy=0 and the bypassed data.
- Reset (asynchronous): pending=0, last_grant=B, bypass valid=0, busy_a/b=0, primed=0.
  - wa_ready and wb_ready are forced 0 while reset is asserted.
  - rd_data_a/b are forced 0 until primed, which sets on the first clock edge after reset deasserts.
  - Storage contents are not cleared.
- Reset asserted mid-handshake: no commit occurs. The requester must re-present after reset.

## Timing
- Write: commit at edge N; visible to a read sampled at edge N (via bypass) or later.
- Read: address sampled at edge N; rd_data/busy valid throughout cycle N+1.
- Reserve at edge N: busy=1 for a read sampled at edge N or later.
- Contention: with both requesters continuously valid, grants alternate A,B,A,B. Each requester waits at most one cycle.
- Throughput: one write per cycle; two reads per cycle, independent of writes.

## Structure
- Package regfile_arb_pkg:
  - GRANT_A=1'b0 and GRANT_B=1'b1.
  - Default width constants.
- Storage is the existing r2w1_port_ram, instantiated once.
- The scoreboard is a natural sub-module, regfile_scoreboard:
  - inputs: set/clear ports
  - outputs: bitmap, plus two registered lookups producing busy_a/b
- Arbiter and bypass stay inline.

## Test plan
- Reset release: rd_data_a/b=0 and busy=0 on the first cycle; wa_valid=1 during reset gives wa_ready=0.
- Contention: A writes r3=0x11 and B writes r4=0x22, both valid at the same edge.
  - A is granted first, B one cycle later.
  - Reads of r3 and r4 then return 0x11 and 0x22.
- Bypass: A writes r7=0xDEAD while rd_addr_a=7 is sampled in the same cycle; the next cycle rd_data_a=0xDEAD and busy_a=0.
- Scoreboard:
  - rsv r9, then read r9 gives busy_b=1.
  - B commits r9=0x5A5A; the read sampled at that edge gives busy_b=0 and data 0x5A5A; pending[9]=0.
- Set/clear collision: B commits r2 while rsv_addr=2 in the same cycle; pending[2] stays 1.
- Hold: B holds valid for 3 cycles against continuous A with changing A data; each of A and B gets alternate grants, and B's addr/data are written unchanged.
